// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: REQ/HOLD fetch FSM, PC tracking, bus PC load.
// Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer filled while in HOLD.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_done,
  input  logic        pc_load,
  input  logic [15:0] pc_bus,
  output logic [15:0] pc
);

  typedef enum logic {S_REQ, S_HOLD} state_t;

  state_t state;
  logic   accept;

  // An ack only counts against a request that is actually on the bus.
  assign accept = mem_req & mem_ack;

`ifdef FETCH_PREFETCH_EN
  logic        buf_valid;
  logic [15:0] buf_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_REQ;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      buf_valid   <= 1'b0;
      buf_data    <= 16'h0000;
`endif
    end else if (pc_load) begin
      // Redirect wins over everything: drop held word, ack data and buffer.
      state       <= S_REQ;
      mem_req     <= 1'b1;
      mem_addr    <= pc_bus;
      pc          <= pc_bus;
      instr_valid <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      buf_valid   <= 1'b0;
`endif
    end else begin
      case (state)
        S_REQ: begin
          if (accept) begin
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
            pc          <= mem_addr + 16'd1;
            mem_addr    <= mem_addr + 16'd1;
            state       <= S_HOLD;
`ifdef FETCH_PREFETCH_EN
            mem_req     <= 1'b1;
            buf_valid   <= 1'b0;
`else
            mem_req     <= 1'b0;
`endif
          end else begin
            mem_req <= 1'b1;
          end
        end
        S_HOLD: begin
`ifdef FETCH_PREFETCH_EN
          // While holding, mem_addr tracks pc, i.e. the next sequential word.
          if (instr_done && buf_valid) begin
            instr     <= buf_data;
            pc        <= pc + 16'd1;
            mem_addr  <= pc + 16'd1;
            mem_req   <= 1'b1;
            buf_valid <= 1'b0;
          end else if (instr_done) begin
            state       <= S_REQ;
            instr_valid <= 1'b0;
            mem_req     <= 1'b1;
          end else if (accept) begin
            buf_data  <= mem_rdata;
            buf_valid <= 1'b1;
            mem_req   <= 1'b0;
          end
`else
          if (instr_done) begin
            state       <= S_REQ;
            instr_valid <= 1'b0;
            mem_req     <= 1'b1;
            mem_addr    <= pc;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch (RESET_PC=16'h0010).
module tb_instr_fetch;

`ifdef FETCH_PREFETCH_EN
  localparam logic PF = 1'b1;
`else
  localparam logic PF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_done;
  logic        pc_load;
  logic [15:0] pc_bus;
  logic [15:0] pc;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch #(.RESET_PC(16'h0010)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_done  (instr_done),
    .pc_load     (pc_load),
    .pc_bus      (pc_bus),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    instr_done = 1'b0; pc_load = 1'b0; pc_bus = 16'h0000;
    tick(); tick();
    check("rst_mem_req", {15'd0, mem_req}, 16'd0);
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_instr", instr, 16'h0000);
    check("rst_pc", pc, 16'h0010);
    check("rst_addr", mem_addr, 16'h0010);

    // First fetch after release.
    rst = 1'b1;
    tick();
    check("rel_mem_req", {15'd0, mem_req}, 16'd1);
    check("rel_addr", mem_addr, 16'h0010);
    mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    tick();
    mem_ack = 1'b0;
    check("f0_instr", instr, 16'hA5A5);
    check("f0_valid", {15'd0, instr_valid}, 16'd1);
    check("f0_pc", pc, 16'h0011);
    check("f0_mem_req", {15'd0, mem_req}, {15'd0, PF});

    // Sequential fetches at 0,1,2 with a 2-cycle ack wait each.
    pc_load = 1'b1; pc_bus = 16'h0000;
    tick();
    pc_load = 1'b0;
    check("ld0_valid", {15'd0, instr_valid}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 2; w++) begin
        check("seq_wait_addr", mem_addr, 16'(i));
        check("seq_wait_req", {15'd0, mem_req}, 16'd1);
        tick();
      end
      mem_ack = 1'b1; mem_rdata = 16'h1000 + 16'(i);
      tick();
      mem_ack = 1'b0;
      check("seq_instr", instr, 16'h1000 + 16'(i));
      check("seq_valid", {15'd0, instr_valid}, 16'd1);
      check("seq_pc", pc, 16'(i + 1));
      instr_done = 1'b1;
      tick();
      instr_done = 1'b0;
      check("seq_next_req", {15'd0, mem_req}, 16'd1);
      check("seq_next_addr", mem_addr, 16'(i + 1));
      check("seq_next_valid", {15'd0, instr_valid}, 16'd0);
    end

    // instr_done while in REQ is ignored.
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    check("done_in_req_addr", mem_addr, 16'h0003);
    check("done_in_req_valid", {15'd0, instr_valid}, 16'd0);

    // pc_load in the same cycle as mem_ack drops the data.
    mem_ack = 1'b1; mem_rdata = 16'hDEAD; pc_load = 1'b1; pc_bus = 16'h0200;
    tick();
    mem_ack = 1'b0; pc_load = 1'b0;
    check("ldack_valid", {15'd0, instr_valid}, 16'd0);
    check("ldack_addr", mem_addr, 16'h0200);
    check("ldack_req", {15'd0, mem_req}, 16'd1);
    check("ldack_pc", pc, 16'h0200);
    tick();
    check("ldack_valid2", {15'd0, instr_valid}, 16'd0);

    // PC wrap at 16'hFFFF.
    pc_load = 1'b1; pc_bus = 16'hFFFF;
    tick();
    pc_load = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    check("wrap_instr", instr, 16'hBEEF);
    check("wrap_pc", pc, 16'h0000);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    check("wrap_addr", mem_addr, 16'h0000);
    check("wrap_req", {15'd0, mem_req}, 16'd1);

    // Reset mid-fetch with a stray ack on the release edge.
    rst = 1'b0;
    tick();
    check("midrst_req", {15'd0, mem_req}, 16'd0);
    check("midrst_addr", mem_addr, 16'h0010);
    check("midrst_pc", pc, 16'h0010);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hBAD0;
    tick();
    mem_ack = 1'b0;
    check("stray_valid", {15'd0, instr_valid}, 16'd0);
    check("stray_addr", mem_addr, 16'h0010);
    check("stray_req", {15'd0, mem_req}, 16'd1);
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0;
    check("post_rst_instr", instr, 16'h1234);
    check("post_rst_pc", pc, 16'h0011);

    // pc_load together with instr_done acts as pc_load alone.
    pc_load = 1'b1; instr_done = 1'b1; pc_bus = 16'h0300;
    tick();
    pc_load = 1'b0; instr_done = 1'b0;
    check("lddone_valid", {15'd0, instr_valid}, 16'd0);
    check("lddone_addr", mem_addr, 16'h0300);
    check("lddone_pc", pc, 16'h0300);

`ifdef FETCH_PREFETCH_EN
    mem_ack = 1'b1; mem_rdata = 16'h3000;
    tick();
    check("pf_hold_addr", mem_addr, 16'h0301);
    check("pf_hold_req", {15'd0, mem_req}, 16'd1);
    mem_rdata = 16'h3001;
    tick();
    mem_ack = 1'b0;
    check("pf_full_req", {15'd0, mem_req}, 16'd0);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    check("pf_b2b_valid", {15'd0, instr_valid}, 16'd1);
    check("pf_b2b_instr", instr, 16'h3001);
    check("pf_b2b_pc", pc, 16'h0302);
    check("pf_b2b_addr", mem_addr, 16'h0302);
    mem_ack = 1'b1; mem_rdata = 16'h3002;
    tick();
    mem_ack = 1'b0;
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    check("pf_b2b2_valid", {15'd0, instr_valid}, 16'd1);
    check("pf_b2b2_instr", instr, 16'h3002);
    mem_ack = 1'b1; mem_rdata = 16'h3003;
    tick();
    mem_ack = 1'b0;
    pc_load = 1'b1; pc_bus = 16'h0400;
    tick();
    pc_load = 1'b0;
    check("pf_flush_valid", {15'd0, instr_valid}, 16'd0);
    check("pf_flush_addr", mem_addr, 16'h0400);
    mem_ack = 1'b1; mem_rdata = 16'h4000;
    tick();
    mem_ack = 1'b0;
    check("pf_flush_instr", instr, 16'h4000);
    check("pf_flush_pc", pc, 16'h0401);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
